// File: rtl/ptw_mlvl.sv
// Multi-level page-table walker with a single outstanding PTE read.
// Optional root-level walk cache is enabled by defining PTW_WALK_CACHE_EN.
module ptw_mlvl #(
  parameter int              LEVELS    = 2,
  parameter int              VPN_W     = 10,
  parameter int              VA_W      = 32,
  parameter int              PA_W      = 32,
  parameter logic [PA_W-1:0] ROOT_BASE = PA_W'(32'h400)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ptw_req_valid_i,
  output logic            ptw_req_ready_o,
  input  logic [VA_W-1:0] ptw_vaddr_i,
  output logic            ptw_resp_valid_o,
  input  logic            ptw_resp_ready_i,
  output logic [31:0]     ptw_pte_o,
  output logic [1:0]      ptw_level_o,
  output logic            ptw_fault_o,
  input  logic            ptw_flush_i,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [PA_W-1:0] mem_addr_o,
  input  logic            mem_resp_valid_i,
  output logic            mem_resp_ready_o,
  input  logic [31:0]     mem_data_i
);

  typedef enum logic [1:0] {IDLE, MREQ, MWAIT, RESP} state_t;

  localparam logic [1:0] ROOT_LVL = 2'(LEVELS - 1);

  state_t          state;
  logic [VA_W-1:0] vaddr_q;
  logic [1:0]      level_q;

  function automatic logic [VPN_W-1:0] vpn_of(input logic [VA_W-1:0] va, input logic [1:0] lvl);
    return VPN_W'(va >> (12 + VPN_W * int'(lvl)));
  endfunction

  function automatic logic [PA_W-1:0] pte_addr(input logic [PA_W-1:0] base,
                                               input logic [VA_W-1:0] va,
                                               input logic [1:0]      lvl);
    return base + (PA_W'(vpn_of(va, lvl)) << 2);
  endfunction

  logic            pte_v, pte_r, pte_w, pte_x, pte_leaf, pte_fault;
  logic [PA_W-1:0] next_base;

  assign pte_v     = mem_data_i[0];
  assign pte_r     = mem_data_i[1];
  assign pte_w     = mem_data_i[2];
  assign pte_x     = mem_data_i[3];
  assign pte_leaf  = pte_r | pte_x;
  assign pte_fault = !pte_v || (pte_w && !pte_r) || (!pte_leaf && level_q == 2'd0);
  assign next_base = PA_W'({mem_data_i[31:10], 10'b0});

`ifdef PTW_WALK_CACHE_EN
  logic             cache_valid;
  logic [VPN_W-1:0] cache_tag;
  logic [PA_W-1:0]  cache_base;
  logic             cache_hit;

  // A flush in the acceptance cycle also suppresses the hit, so a flushed entry is never used.
  assign cache_hit = (LEVELS > 1) && cache_valid && !ptw_flush_i &&
                     (cache_tag == vpn_of(ptw_vaddr_i, ROOT_LVL));
`else
  logic unused_flush;
  assign unused_flush = ptw_flush_i;
`endif

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // branch below sees pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      vaddr_q          <= '0;
      level_q          <= '0;
      ptw_req_ready_o  <= 1'b1;
      ptw_resp_valid_o <= 1'b0;
      ptw_pte_o        <= '0;
      ptw_level_o      <= '0;
      ptw_fault_o      <= 1'b0;
      mem_req_valid_o  <= 1'b0;
      mem_resp_ready_o <= 1'b0;
      mem_addr_o       <= '0;
`ifdef PTW_WALK_CACHE_EN
      // NOTE: only the valid bit needs reset; tag and base are never read while invalid.
      cache_valid      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ptw_req_valid_i) begin
            vaddr_q         <= ptw_vaddr_i;
            ptw_req_ready_o <= 1'b0;
            mem_req_valid_o <= 1'b1;
            state           <= MREQ;
`ifdef PTW_WALK_CACHE_EN
            if (cache_hit) begin
              level_q    <= 2'(LEVELS - 2);
              mem_addr_o <= pte_addr(cache_base, ptw_vaddr_i, 2'(LEVELS - 2));
            end else
`endif
            begin
              level_q    <= ROOT_LVL;
              mem_addr_o <= pte_addr(ROOT_BASE, ptw_vaddr_i, ROOT_LVL);
            end
          end
        end

        MREQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o  <= 1'b0;
            mem_resp_ready_o <= 1'b1;
            state            <= MWAIT;
          end
        end

        MWAIT: begin
          if (mem_resp_valid_i) begin
            mem_resp_ready_o <= 1'b0;
            if (pte_fault || pte_leaf) begin
              ptw_pte_o        <= mem_data_i;
              ptw_level_o      <= level_q;
              ptw_fault_o      <= pte_fault;
              ptw_resp_valid_o <= 1'b1;
              state            <= RESP;
            end else begin
              // Valid pointer above level 0: descend one level.
              level_q         <= level_q - 2'd1;
              mem_addr_o      <= pte_addr(next_base, vaddr_q, level_q - 2'd1);
              mem_req_valid_o <= 1'b1;
              state           <= MREQ;
`ifdef PTW_WALK_CACHE_EN
              if (level_q == ROOT_LVL) begin
                cache_valid <= 1'b1;
                cache_tag   <= vpn_of(vaddr_q, ROOT_LVL);
                cache_base  <= next_base;
              end
`endif
            end
          end
        end

        RESP: begin
          if (ptw_resp_ready_i) begin
            ptw_resp_valid_o <= 1'b0;
            ptw_req_ready_o  <= 1'b1;
            state            <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

`ifdef PTW_WALK_CACHE_EN
      // Last assignment wins: flush beats a same-cycle fill.
      if (ptw_flush_i) cache_valid <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_ptw_mlvl.sv
// Directed self-checking bench for ptw_mlvl (LEVELS=2) with a small PTE memory model.
// Cache-dependent expectations follow PTW_WALK_CACHE_EN.
module tb_ptw_mlvl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ptw_req_valid_i;
  logic        ptw_req_ready_o;
  logic [31:0] ptw_vaddr_i;
  logic        ptw_resp_valid_o;
  logic        ptw_resp_ready_i;
  logic [31:0] ptw_pte_o;
  logic [1:0]  ptw_level_o;
  logic        ptw_fault_o;
  logic        ptw_flush_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_resp_valid_i;
  logic        mem_resp_ready_o;
  logic [31:0] mem_data_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_log[$];
  logic        mem_resp_en = 1'b1;

  always #5 clk = ~clk;

  ptw_mlvl dut (
    .clk              (clk),
    .rst              (rst),
    .ptw_req_valid_i  (ptw_req_valid_i),
    .ptw_req_ready_o  (ptw_req_ready_o),
    .ptw_vaddr_i      (ptw_vaddr_i),
    .ptw_resp_valid_o (ptw_resp_valid_o),
    .ptw_resp_ready_i (ptw_resp_ready_i),
    .ptw_pte_o        (ptw_pte_o),
    .ptw_level_o      (ptw_level_o),
    .ptw_fault_o      (ptw_fault_o),
    .ptw_flush_i      (ptw_flush_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_addr_o       (mem_addr_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_ready_o (mem_resp_ready_o),
    .mem_data_i       (mem_data_i)
  );

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    case (a)
      32'h400: return 32'h0000_0801;
      32'h404: return 32'h1234_0007;
      32'h800: return 32'h1000_000F;
      32'h804: return 32'h1100_000F;
      default: return 32'h0;
    endcase
  endfunction

  // Memory model: one response per accepted request, presented the cycle after acceptance.
  initial begin
    logic        pending;
    logic [31:0] pdata;
    logic        hs_req, hs_resp, rst_s;
    logic [31:0] addr_s;
    pending = 1'b0;
    pdata = '0;
    mem_resp_valid_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk);
      hs_req  = mem_req_valid_o && mem_req_ready_i && !rst;
      hs_resp = mem_resp_valid_i && mem_resp_ready_o;
      addr_s  = mem_addr_o;
      rst_s   = rst;
      #1;
      if (hs_resp) pending = 1'b0;
      if (hs_req) begin
        pending = 1'b1;
        pdata = mem_read(addr_s);
        rd_log.push_back(addr_s);
      end
      if (rst_s) pending = 1'b0;
      mem_resp_valid_i = pending && mem_resp_en;
      mem_data_i = pdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_walk(input logic [31:0] va, input bit flush,
                         output logic [31:0] pte, output logic [1:0] lvl,
                         output logic flt, output int lat);
    @(negedge clk);
    ptw_flush_i = flush;
    @(negedge clk);
    ptw_flush_i = 1'b0;
    rd_log.delete();
    ptw_vaddr_i = va;
    ptw_req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    ptw_req_valid_i = 1'b0;
    lat = 0;
    while (!ptw_resp_valid_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (ptw_resp_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL walk_timeout va=%h got resp_valid=%b exp=1", va, ptw_resp_valid_o);
    end
    pte = ptw_pte_o;
    lvl = ptw_level_o;
    flt = ptw_fault_o;
    ptw_resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    ptw_resp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ptw_req_ready_o, ptw_resp_valid_o, mem_req_valid_o, mem_resp_ready_o} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_handshake got=%b exp=1000",
               {ptw_req_ready_o, ptw_resp_valid_o, mem_req_valid_o, mem_resp_ready_o});
    end
    checks++;
    if ({ptw_pte_o, ptw_level_o, ptw_fault_o} !== 35'h0) begin
      errors++;
      $display("FAIL reset_result got pte=%h lvl=%0d flt=%b exp all zero", ptw_pte_o, ptw_level_o, ptw_fault_o);
    end
    checks++;
    if (mem_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_addr got=%h exp=0", mem_addr_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_two_level();
    logic [31:0] pte; logic [1:0] lvl; logic flt; int lat;
    do_walk(32'h0000_1000, 1'b1, pte, lvl, flt, lat);
    checks++;
    if ({pte, lvl, flt} !== {32'h1100_000F, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL two_level_result got pte=%h lvl=%0d flt=%b exp pte=1100000f lvl=0 flt=0", pte, lvl, flt);
    end
    checks++;
    if (!(rd_log.size() == 2 && rd_log[0] == 32'h400 && rd_log[1] == 32'h804)) begin
      errors++;
      $display("FAIL two_level_reads got n=%0d exp reads 400,804", rd_log.size());
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL two_level_latency got=%0d exp=4", lat);
    end
  endtask

  task automatic test_superpage();
    logic [31:0] pte; logic [1:0] lvl; logic flt; int lat;
    do_walk(32'h0040_0000, 1'b1, pte, lvl, flt, lat);
    checks++;
    if ({pte, lvl, flt} !== {32'h1234_0007, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL superpage_result got pte=%h lvl=%0d flt=%b exp pte=12340007 lvl=1 flt=0", pte, lvl, flt);
    end
    checks++;
    if (!(rd_log.size() == 1 && rd_log[0] == 32'h404)) begin
      errors++;
      $display("FAIL superpage_reads got n=%0d exp single read 404", rd_log.size());
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL superpage_latency got=%0d exp=2", lat);
    end
  endtask

  task automatic test_faults();
    logic [31:0] pte; logic [1:0] lvl; logic flt; int lat;
    do_walk(32'h8000_0000, 1'b1, pte, lvl, flt, lat);
    checks++;
    if ({pte, lvl, flt} !== {32'h0, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL root_fault_result got pte=%h lvl=%0d flt=%b exp pte=0 lvl=1 flt=1", pte, lvl, flt);
    end
    checks++;
    if (!(rd_log.size() == 1 && rd_log[0] == 32'hC00)) begin
      errors++;
      $display("FAIL root_fault_reads got n=%0d exp single read c00", rd_log.size());
    end
    do_walk(32'h0000_3000, 1'b1, pte, lvl, flt, lat);
    checks++;
    if ({pte, lvl, flt} !== {32'h0, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL leaf_fault_result got pte=%h lvl=%0d flt=%b exp pte=0 lvl=0 flt=1", pte, lvl, flt);
    end
    checks++;
    if (!(rd_log.size() == 2 && rd_log[0] == 32'h400 && rd_log[1] == 32'h80C)) begin
      errors++;
      $display("FAIL leaf_fault_reads got n=%0d exp reads 400,80c", rd_log.size());
    end
  endtask

  task automatic test_back_pressure();
    int n;
    @(negedge clk);
    mem_req_ready_i = 1'b0;
    rd_log.delete();
    ptw_vaddr_i = 32'h0040_0000;
    ptw_req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    ptw_req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({mem_req_valid_o, ptw_req_ready_o, mem_addr_o} !== {1'b1, 1'b0, 32'h404}) begin
        errors++;
        $display("FAIL mreq_stall_%0d got valid=%b ready=%b addr=%h exp valid=1 ready=0 addr=404",
                 i, mem_req_valid_o, ptw_req_ready_o, mem_addr_o);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    mem_req_ready_i = 1'b1;
    n = 0;
    while (!ptw_resp_valid_o && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    // Hold the result for 5 cycles while a competing request is offered.
    ptw_vaddr_i = 32'h0;
    ptw_req_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({ptw_resp_valid_o, ptw_req_ready_o, ptw_pte_o, ptw_level_o, ptw_fault_o} !==
          {1'b1, 1'b0, 32'h1234_0007, 2'd1, 1'b0}) begin
        errors++;
        $display("FAIL resp_hold_%0d got valid=%b ready=%b pte=%h lvl=%0d flt=%b exp valid=1 ready=0 pte=12340007 lvl=1 flt=0",
                 i, ptw_resp_valid_o, ptw_req_ready_o, ptw_pte_o, ptw_level_o, ptw_fault_o);
      end
      if (i < 5) begin
        @(posedge clk);
        #1;
      end
    end
    ptw_resp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    ptw_resp_ready_i = 1'b0;
    ptw_req_valid_i = 1'b0;
    checks++;
    if ({ptw_req_ready_o, ptw_resp_valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL resp_release got ready=%b valid=%b exp ready=1 valid=0", ptw_req_ready_o, ptw_resp_valid_o);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rd_log.size() != 1 || mem_req_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL no_accept_during_walk got reads=%0d mem_req_valid=%b exp reads=1 mem_req_valid=0",
               rd_log.size(), mem_req_valid_o);
    end
  endtask

  task automatic test_reset_mid_walk();
    logic [31:0] pte; logic [1:0] lvl; logic flt; int lat; int n; bit seen;
    @(negedge clk);
    mem_resp_en = 1'b0;
    ptw_vaddr_i = 32'h0000_1000;
    ptw_req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    ptw_req_valid_i = 1'b0;
    n = 0;
    while (!mem_resp_ready_o && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (mem_resp_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reach_mwait got mem_resp_ready=%b exp=1", mem_resp_ready_o);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({ptw_req_ready_o, ptw_resp_valid_o, mem_resp_ready_o, mem_req_valid_o} !== 4'b1000) begin
      errors++;
      $display("FAIL abort_state got=%b exp=1000",
               {ptw_req_ready_o, ptw_resp_valid_o, mem_resp_ready_o, mem_req_valid_o});
    end
    @(negedge clk);
    rst = 1'b0;
    mem_resp_en = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (ptw_resp_valid_o) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_resp got resp_valid seen=1 exp=0");
    end
    do_walk(32'h0000_0000, 1'b0, pte, lvl, flt, lat);
    checks++;
    if ({pte, lvl, flt} !== {32'h1000_000F, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL after_abort_result got pte=%h lvl=%0d flt=%b exp pte=1000000f lvl=0 flt=0", pte, lvl, flt);
    end
    checks++;
    if (!(rd_log.size() == 2 && rd_log[0] == 32'h400 && rd_log[1] == 32'h800)) begin
      errors++;
      $display("FAIL after_abort_reads got n=%0d exp reads 400,800", rd_log.size());
    end
  endtask

  task automatic test_walk_cache();
    logic [31:0] pte; logic [1:0] lvl; logic flt; int lat;
    do_walk(32'h0000_0000, 1'b1, pte, lvl, flt, lat);
    checks++;
    if (pte !== 32'h1000_000F) begin
      errors++;
      $display("FAIL cache_fill_pte got=%h exp=1000000f", pte);
    end
    do_walk(32'h0000_2000, 1'b0, pte, lvl, flt, lat);
    checks++;
    if ({pte, lvl, flt} !== {32'h0, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL cache_walk_result got pte=%h lvl=%0d flt=%b exp pte=0 lvl=0 flt=1", pte, lvl, flt);
    end
`ifdef PTW_WALK_CACHE_EN
    checks++;
    if (!(rd_log.size() == 1 && rd_log[0] == 32'h808) || lat != 2) begin
      errors++;
      $display("FAIL cache_hit_reads got n=%0d lat=%0d exp single read 808 lat=2", rd_log.size(), lat);
    end
`else
    checks++;
    if (!(rd_log.size() == 2 && rd_log[0] == 32'h400 && rd_log[1] == 32'h808) || lat != 4) begin
      errors++;
      $display("FAIL nocache_reads got n=%0d lat=%0d exp reads 400,808 lat=4", rd_log.size(), lat);
    end
`endif
    do_walk(32'h0000_2000, 1'b1, pte, lvl, flt, lat);
    checks++;
    if (!(rd_log.size() == 2 && rd_log[0] == 32'h400 && rd_log[1] == 32'h808)) begin
      errors++;
      $display("FAIL flush_reads got n=%0d exp reads 400,808", rd_log.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    ptw_req_valid_i = 1'b0;
    ptw_vaddr_i = '0;
    ptw_resp_ready_i = 1'b0;
    ptw_flush_i = 1'b0;
    mem_req_ready_i = 1'b1;
    test_reset();
    test_two_level();
    test_superpage();
    test_faults();
    test_back_pressure();
    test_reset_mid_walk();
    test_walk_cache();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
